// File: rtl/booth_mult_32_pkg.sv
// Shared widths, step count, FSM encoding and the Booth sign-bit helper.
package booth_mult_32_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MULT_STEPS = 32;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_t;

    // Bit 32 of the true 33-bit add/sub result. It replaces the adder MSB as the
    // shifted-in sign so that ACC -/+ M cannot overflow (e.g. M = -2^31).
    function automatic logic add_sub_sign(input logic acc_msb, input logic m_msb,
                                          input logic sna, input logic co);
        return acc_msb ^ m_msb ^ sna ^ co;
    endfunction

endpackage

// File: rtl/booth_mult_32_if.sv
// Request/result bundle between the ALU (master) and the Booth multiplier (slave).
interface booth_mult_32_if;
    import booth_mult_32_pkg::*;

    logic                  start;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [DATA_WIDTH-1:0] product_hi;
    logic [DATA_WIDTH-1:0] product_lo;
    logic                  busy;
    logic                  done;

    modport master (
        output start, op1, op2,
        input  product_hi, product_lo, busy, done
    );

    modport slave (
        input  start, op1, op2,
        output product_hi, product_lo, busy, done
    );

endinterface

// File: rtl/booth_mult_32_add_sub.sv
// 32-bit adder/subtractor: y = a + b when sna = 0, y = a - b when sna = 1.
// co is the carry out of a + (b ^ {32{sna}}) + sna.
module rc_add_sub_32
    import booth_mult_32_pkg::*;
(
    output logic [DATA_WIDTH-1:0] y,
    output logic                  co,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sna
);

    logic [DATA_WIDTH-1:0] b_eff;

    assign b_eff   = b ^ {DATA_WIDTH{sna}};
    assign {co, y} = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sna};

endmodule

// File: rtl/booth_mult_32.sv
// Sequential radix-2 Booth multiplier, 32x32 signed -> 64-bit product.
// One add/sub and one arithmetic right shift of {ACC, Q, Q_1} per clock.
module booth_mult_32
    import booth_mult_32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    booth_mult_32_if.slave  bus
);

    mult_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] m_q, acc_q, q_q;
    logic                  q_1_q;
    logic [5:0]            cnt_q;
    logic [DATA_WIDTH-1:0] prod_hi_q, prod_lo_q;

    logic                  sna, co, do_op, sx, last_step;
    logic [DATA_WIDTH-1:0] y, s, acc_next, q_next;

    // Booth pair {Q[0], Q_1}: 10 subtracts M, 01 adds M, 00/11 pass ACC through.
    assign sna       = q_q[0] & ~q_1_q;
    assign do_op     = q_q[0] ^ q_1_q;
    assign last_step = (cnt_q == 6'(MULT_STEPS - 1));

    rc_add_sub_32 u_add_sub (
        .y   (y),
        .co  (co),
        .a   (acc_q),
        .b   (m_q),
        .sna (sna)
    );

    assign s        = do_op ? y : acc_q;
    assign sx       = do_op ? add_sub_sign(acc_q[DATA_WIDTH-1], m_q[DATA_WIDTH-1], sna, co)
                            : acc_q[DATA_WIDTH-1];
    assign acc_next = {sx, s[DATA_WIDTH-1:1]};
    assign q_next   = {s[0], q_q[DATA_WIDTH-1:1]};

    // State register; reset wins over everything, including a concurrent START.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always written with <= so every register
        // samples pre-edge values, independent of statement order.
        if (rst) state_q <= MULT_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: IDLE -> RUN on START, RUN for 32 steps, one DONE cycle.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            MULT_IDLE: if (bus.start) state_d = MULT_RUN;
            MULT_RUN:  if (last_step) state_d = MULT_DONE;
            MULT_DONE: state_d = MULT_IDLE;
            default:   state_d = MULT_IDLE;
        endcase
    end

    // Datapath: operand capture on accept, Booth step in RUN, product latch on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            q_1_q     <= 1'b0;
            cnt_q     <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            unique case (state_q)
                MULT_IDLE: begin
                    if (bus.start) begin
                        m_q   <= bus.op1;
                        q_q   <= bus.op2;
                        acc_q <= '0;
                        q_1_q <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                MULT_RUN: begin
                    acc_q <= acc_next;
                    q_q   <= q_next;
                    q_1_q <= q_q[0];
                    cnt_q <= cnt_q + 6'd1;
                    if (last_step) begin
                        prod_hi_q <= acc_next;
                        prod_lo_q <= q_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.product_hi = prod_hi_q;
    assign bus.product_lo = prod_lo_q;
    assign bus.busy       = (state_q == MULT_RUN);
    assign bus.done       = (state_q == MULT_DONE);

endmodule
